// File: rtl/reg_file_alu_pkg.sv
// Shared types for the pipelined register-file/ALU datapath.
package reg_file_alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLL   = 3'b101,
    ALU_SRL   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/reg_file_alu_pipe_alu_core.sv
// Combinational eight-operation ALU with NZCV flag generation.
module alu_core
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] wide;

  // Result and flags for the selected operation; Z and N come from the result.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wide   = '0;
    result = '0;
    flags  = '0;
    case (op)
      ALU_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        result  = wide[MSB:0];
        flags.c = wide[DATA_W];
        flags.v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // The extra top bit of the widened difference is the borrow (A < B).
        wide    = {1'b0, a} - {1'b0, b};
        result  = wide[MSB:0];
        flags.c = wide[DATA_W];
        flags.v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: begin
        result  = {a[MSB-1:0], 1'b0};
        flags.c = a[MSB];
      end
      ALU_SRL: begin
        result  = {1'b0, a[MSB:1]};
        flags.c = a[0];
      end
      ALU_PASSB: result = b;
    endcase
    flags.z = (result == '0);
    flags.n = result[MSB];
  end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register file + ALU: ID/EX register, EX-to-read forwarding,
// registered result/flags/store-data outputs and a valid bit through the pipe.
module reg_file_alu_pipe
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 16,
  parameter int ADDR_W  = $clog2(NREGS),
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] immediate,
  input  logic [2:0]        alu_ctrl,
  input  logic              write_enable,
  input  logic              alu_src,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] cpu_out,
  output logic              zero,
  output logic              negative,
  output logic              carry,
  output logic              overflow,
  output logic              out_valid
);

  // Register file
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // ID/EX register
  logic              ex_valid_q, ex_valid_d;
  alu_op_t           ex_op_q,    ex_op_d;
  logic [ADDR_W-1:0] ex_wa_q,    ex_wa_d;
  logic              ex_we_q,    ex_we_d;
  logic [DATA_W-1:0] ex_a_q,     ex_a_d;
  logic [DATA_W-1:0] ex_b_q,     ex_b_d;
  logic [DATA_W-1:0] ex_rd2_q,   ex_rd2_d;

  // Output register
  logic [DATA_W-1:0] res_q,   res_d;
  logic [DATA_W-1:0] cpu_q,   cpu_d;
  alu_flags_t        flags_q, flags_d;
  logic              ov_q,    ov_d;

  logic [DATA_W-1:0] ex_res;
  alu_flags_t        ex_flags;
  logic              ex_commit;
  logic [DATA_W-1:0] rd1, rd2;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (ex_a_q),
    .b      (ex_b_q),
    .op     (ex_op_q),
    .result (ex_res),
    .flags  (ex_flags)
  );

  // EX writes back (and forwards) only for a valid writing op not aimed at a hard-wired r0.
  assign ex_commit = ex_valid_q && ex_we_q && !((R0_ZERO != 0) && (ex_wa_q == '0));

  // Operand reads with r0 masking and forwarding of the EX result being written this edge.
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
    if (ex_commit && (ex_wa_q == ra1)) rd1 = ex_res;
    if (ex_commit && (ex_wa_q == ra2)) rd2 = ex_res;
    if ((R0_ZERO != 0) && (ra1 == '0)) rd1 = '0;
    if ((R0_ZERO != 0) && (ra2 == '0)) rd2 = '0;
  end

  // Next-state for ID/EX capture, output register and register-file write-back.
  always_comb begin
    ex_valid_d = in_valid;
    ex_op_d    = ex_op_q;
    ex_wa_d    = ex_wa_q;
    ex_we_d    = ex_we_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_rd2_d   = ex_rd2_q;
    if (in_valid) begin
      ex_op_d  = alu_op_t'(alu_ctrl);
      ex_wa_d  = wa;
      ex_we_d  = write_enable;
      ex_a_d   = rd1;
      ex_b_d   = alu_src ? immediate : rd2;
      ex_rd2_d = rd2;
    end

    // Bubbles hold the previous outputs; only out_valid drops.
    ov_d    = ex_valid_q;
    res_d   = res_q;
    cpu_d   = cpu_q;
    flags_d = flags_q;
    if (ex_valid_q) begin
      res_d   = ex_res;
      cpu_d   = ex_rd2_q;
      flags_d = ex_flags;
    end

    regs_d = regs_q;
    if (ex_commit) regs_d[ex_wa_q] = ex_res;
  end

  // State update; reset also clears the register file and drops any in-flight op.
  // NOTE: flops take non-blocking assignments so all of them update from pre-edge values.
  // NOTE: the register file is reset because software relies on it reading zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '{default: '0};
      ex_valid_q <= 1'b0;
      ex_op_q    <= ALU_ADD;
      ex_wa_q    <= '0;
      ex_we_q    <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_rd2_q   <= '0;
      res_q      <= '0;
      cpu_q      <= '0;
      flags_q    <= '0;
      ov_q       <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_wa_q    <= ex_wa_d;
      ex_we_q    <= ex_we_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_rd2_q   <= ex_rd2_d;
      res_q      <= res_d;
      cpu_q      <= cpu_d;
      flags_q    <= flags_d;
      ov_q       <= ov_d;
    end
  end

  assign alu_result = res_q;
  assign cpu_out    = cpu_q;
  assign zero       = flags_q.z;
  assign negative   = flags_q.n;
  assign carry      = flags_q.c;
  assign overflow   = flags_q.v;
  assign out_valid  = ov_q;

endmodule
